uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial-to-parallel UART receiver. It is the far-end counterpart of the UART transmitter: it consumes the serial line the transmitter drives and produces parallel words.
- Shares the transmitter's frame parameters (Data, Parity, Stop) so that paired instances interoperate.
- Sits between a device pin (asynchronous input) and core logic that takes words on a one-cycle valid strobe. There is no backpressure.

Parameters:
- Divisor, 16: clk cycles per bit. Must be even and ≥4.
- Data, 8: data bits per frame, 5..9, sent LSB first.
- Parity, 0: 0 = none, 1 = odd, 2 = even.
- Stop, 1: stop bits, 1 or 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in  in  1  serial line, asynchronous; idles high
- out  out  Data  received word, LSB = first data bit
- valid  out  1  one-cycle strobe; `out` and the error flags are meaningful in this cycle
- parity_error  out  1  parity mismatch for this frame (always 0 when Parity=0)
- frame_error  out  1  a sampled stop bit was 0

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high.
- Reset values: out=0, valid=0, parity_error=0, frame_error=0, state=IDLE, counters=0, sync flops=1.
- Reset mid-frame aborts the frame; no valid is emitted.
- Synchroniser:
  - `in` passes through 2 flops preset to 1; the result is `rx_s`.
  - All decisions use `rx_s` only.
- Edge numbering: edge 0 is the clk edge where the first sync flop captures 0. `rx_s`=0 is first seen by the FSM at edge 2.
- Bit counter: `cnt`, width clog2(Divisor). It resets to 0 on every state entry and on every sample.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: if rx_s=0, go to START with cnt=0 (edge 2).
  - START: at cnt=Divisor/2-1, sample rx_s (edge 2+Divisor/2).
    - 1: glitch; return to IDLE, no output.
    - 0: go to DATA with bit index=0.
  - DATA:
    - Sample rx_s every Divisor cycles (cnt=Divisor-1), i.e. at bit centres.
    - Shift right into shift register; the new bit enters at MSB.
    - After Data samples, go to PARITY if Parity≠0, else STOP.
  - PARITY:
    - Sample once.
    - perr = (XOR of data bits XOR sample) ≠ (Parity==1 ? 1 : 0).
    - Then go to STOP.
  - STOP:
    - Sample Stop times; ferr accumulates if any sample is 0.
    - After the final sample, in the next cycle: out<=shift, parity_error<=perr, frame_error<=ferr, valid<=1.
    - Next state is IDLE if the final sample was 1, else BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Timing:
  - Last sample edge = 2 + Divisor/2 + Divisor·(Data+PB+Stop), where PB = (Parity≠0).
  - valid is high for exactly the cycle after that edge.
  - Defaults: sample at edge 154; valid high between edges 154 and 155.
- Output hold:
  - valid deasserts the following cycle.
  - `out`, parity_error and frame_error hold their values until the next valid.
- Back-to-back frames: the FSM re-arms at mid-stop-bit. A start bit immediately following the stop bit is received with no gap required.
- Line activity during DATA, PARITY or STOP is ignored except at sample points. No oversampling majority vote.
- Frame error data: a frame with a stop error still delivers `out` with frame_error=1. The consumer decides whether to drop it.

Test Plan:
1. Defaults; drive 0xA5 as 1 start + 8 data (LSB first) + 1 stop, 16 clk/bit, start edge at edge 0 → valid single-cycle after edge 154; out=0xA5; both errors 0.
2. Parity=2 (even); send 0x03 with parity bit 1 → out=0x03, parity_error=1. Resend with parity bit 0 → parity_error=0.
3. Hold `in` low for 4 cycles then high (glitch) → no valid; FSM back in IDLE; a following valid frame 0x5A is received correctly.
4. Send 0x3C with stop bit 0, then hold the line low 100 cycles, then high, then send frame 0x81 → first valid: out=0x3C, frame_error=1. No frame while the line is held low. Then out=0x81, frame_error=0.
5. Two frames 0x00 then 0xFF, back-to-back with no idle gap → two valid pulses exactly 160 cycles apart; values correct.
6. Assert reset during DATA bit 4 of a frame, release, then send 0x7E → no valid for the aborted frame; out reads 0 after reset; next valid gives out=0x7E.

Source files
------------

// File: rtl/uart_rx_if.sv
// Parallel-side bundle of the UART receiver: serial line in, received word plus status strobe out.
interface uart_rx_if #(
    parameter int DATA = 8
);
    logic            in;
    logic [DATA-1:0] out;
    logic            valid;
    logic            parity_error;
    logic            frame_error;

    modport master (
        output in,
        input  out,
        input  valid,
        input  parity_error,
        input  frame_error
    );

    modport slave (
        input  in,
        output out,
        output valid,
        output parity_error,
        output frame_error
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: two-flop synchroniser, mid-bit sampling FSM, one-cycle valid strobe with sticky word and error flags.
// States: IDLE wait for low line | START confirm start at half bit | DATA shift bits | PARITY check | STOP check stop bits | BREAK wait for line release
module uart_rx #(
    parameter int DIVISOR = 16,
    parameter int DATA    = 8,
    parameter int PARITY  = 0,
    parameter int STOP    = 1
) (
    input logic       clk,
    input logic       reset,
    uart_rx_if.slave  rx_if
);
    localparam int CW = $clog2(DIVISOR);
    localparam int IW = $clog2(DATA + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIVISOR - 1);
    localparam logic [IW-1:0] DATA_M1 = IW'(DATA - 1);
    localparam logic [IW-1:0] STOP_M1 = IW'(STOP - 1);
    localparam logic          ODD_PAR = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DATA-1:0] shift_q, shift_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic [DATA-1:0] out_q, out_d;
    logic            valid_q, valid_d;
    logic            parity_error_q, parity_error_d;
    logic            frame_error_q, frame_error_d;

    logic rx_s;
    logic tick_half;
    logic tick_full;
    logic ferr_next;

    assign rx_s      = sync2_q;
    assign tick_half = (cnt_q == HALF_M1);
    assign tick_full = (cnt_q == FULL_M1);
    assign ferr_next = ferr_q | ~rx_s;

    always_comb begin
        state_d        = state_q;
        sync1_d        = rx_if.in;
        sync2_d        = sync1_q;
        cnt_d          = cnt_q + CW'(1);
        idx_d          = idx_q;
        shift_d        = shift_q;
        perr_d         = perr_q;
        ferr_d         = ferr_q;
        out_d          = out_q;
        valid_d        = 1'b0;
        parity_error_d = parity_error_q;
        frame_error_d  = frame_error_q;

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                perr_d = 1'b0;
                ferr_d = 1'b0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (tick_half) begin
                    cnt_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick_full) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA-1:1]};
                    if (idx_q == DATA_M1) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick_full) begin
                    cnt_d   = '0;
                    perr_d  = ((^shift_q) ^ rx_s) != ODD_PAR;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick_full) begin
                    cnt_d  = '0;
                    ferr_d = ferr_next;
                    if (idx_q == STOP_M1) begin
                        // Re-arm at mid-stop so a start bit right after the stop bit is caught.
                        idx_d          = '0;
                        out_d          = shift_q;
                        parity_error_d = perr_q;
                        frame_error_d  = ferr_next;
                        valid_d        = 1'b1;
                        state_d        = rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            cnt_q          <= '0;
            idx_q          <= '0;
            shift_q        <= '0;
            perr_q         <= 1'b0;
            ferr_q         <= 1'b0;
            out_q          <= '0;
            valid_q        <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            shift_q        <= shift_d;
            perr_q         <= perr_d;
            ferr_q         <= ferr_d;
            out_q          <= out_d;
            valid_q        <= valid_d;
            parity_error_q <= parity_error_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign rx_if.out          = out_q;
    assign rx_if.valid        = valid_q;
    assign rx_if.parity_error = parity_error_q;
    assign rx_if.frame_error  = frame_error_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames on a no-parity and an even-parity instance, scoreboard-checked at valid.
module tb_uart_rx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_if #(.DATA(8)) if0 ();
    uart_rx_if #(.DATA(8)) if1 ();

    uart_rx #(.DIVISOR(16), .DATA(8), .PARITY(0), .STOP(1)) dut0 (
        .clk   (clk),
        .reset (reset),
        .rx_if (if0.slave)
    );

    uart_rx #(.DIVISOR(16), .DATA(8), .PARITY(2), .STOP(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .rx_if (if1.slave)
    );

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         at;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic pop_chk(input string tag, input exp_t e, input logic [7:0] d,
                           input logic pe, input logic fe);
        chk({tag, "_out"}, {24'd0, d}, {24'd0, e.d});
        chk({tag, "_parity_error"}, {31'd0, pe}, {31'd0, e.pe});
        chk({tag, "_frame_error"}, {31'd0, fe}, {31'd0, e.fe});
        chk({tag, "_valid_cycle"}, cyc, e.at);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (if0.valid === 1'b1) begin
            if (q0.size() == 0) chk("dut0_unexpected_valid", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                pop_chk("dut0", e, if0.out, if0.parity_error, if0.frame_error);
            end
        end
        if (if1.valid === 1'b1) begin
            if (q1.size() == 0) chk("dut1_unexpected_valid", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                pop_chk("dut1", e, if1.out, if1.parity_error, if1.frame_error);
            end
        end
    end

    // Called at a negedge; each bit lasts 16 cycles, first bit is captured at the next posedge.
    task automatic drive_bits(input int sel, input logic [15:0] bits, input int n, output int start);
        start = cyc + 1;
        for (int i = 0; i < n; i++) begin
            if (sel == 0) if0.in = bits[i];
            else          if1.in = bits[i];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic send0(input logic [7:0] d, input logic stop_bit, input logic fe_exp);
        int   st;
        exp_t e;
        st   = cyc + 1;
        e.d  = d;
        e.pe = 1'b0;
        e.fe = fe_exp;
        e.at = st + 154;
        q0.push_back(e);
        drive_bits(0, {6'd0, stop_bit, d, 1'b0}, 10, st);
    endtask

    task automatic send1(input logic [7:0] d, input logic par_bit, input logic pe_exp);
        int   st;
        exp_t e;
        st   = cyc + 1;
        e.d  = d;
        e.pe = pe_exp;
        e.fe = 1'b0;
        e.at = st + 170;
        q1.push_back(e);
        drive_bits(1, {5'd0, 1'b1, par_bit, d, 1'b0}, 11, st);
    endtask

    initial begin
        int st;
        int budget;
        if0.in = 1'b1;
        if1.in = 1'b1;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out", {24'd0, if0.out}, 32'd0);
        chk("rst_valid", {31'd0, if0.valid}, 32'd0);
        chk("rst_parity_error", {31'd0, if0.parity_error}, 32'd0);
        chk("rst_frame_error", {31'd0, if0.frame_error}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 1: basic frame
        send0(8'hA5, 1'b1, 1'b0);
        repeat (50) @(negedge clk);
        chk("hold_out", {24'd0, if0.out}, 32'hA5);
        chk("hold_valid", {31'd0, if0.valid}, 32'd0);

        // 2: even parity, bad then good parity bit
        send1(8'h03, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        chk("par_hold_perr", {31'd0, if1.parity_error}, 32'd1);
        send1(8'h03, 1'b0, 1'b0);
        repeat (20) @(negedge clk);

        // 3: glitch then good frame
        if0.in = 1'b0;
        repeat (4) @(negedge clk);
        if0.in = 1'b1;
        repeat (30) @(negedge clk);
        send0(8'h5A, 1'b1, 1'b0);
        repeat (20) @(negedge clk);

        // 4: frame error, held-low line, recovery
        send0(8'h3C, 1'b0, 1'b1);
        repeat (100) @(negedge clk);
        if0.in = 1'b1;
        repeat (40) @(negedge clk);
        send0(8'h81, 1'b1, 1'b0);
        repeat (20) @(negedge clk);

        // 5: back-to-back frames
        send0(8'h00, 1'b1, 1'b0);
        send0(8'hFF, 1'b1, 1'b0);
        repeat (20) @(negedge clk);

        // 6: reset during data bit 4
        drive_bits(0, {6'd0, 1'b1, 8'h99, 1'b0}, 5, st);
        if0.in = 1'b1;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_out", {24'd0, if0.out}, 32'd0);
        chk("midrst_valid", {31'd0, if0.valid}, 32'd0);
        chk("midrst_frame_error", {31'd0, if0.frame_error}, 32'd0);
        repeat (200) @(negedge clk);
        send0(8'h7E, 1'b1, 1'b0);

        budget = 0;
        while ((q0.size() != 0 || q1.size() != 0) && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        chk("pending_dut0", q0.size(), 32'd0);
        chk("pending_dut1", q1.size(), 32'd0);
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
